des_key_schedule: RTL and testbench

//   Generates the 16 DES 48-bit round keys from a 64-bit cipher key and writes

---
 rtl/des_key_schedule_pkg.sv | 43 ++++
 rtl/des_key_schedule_if.sv | 22 ++
 rtl/des_key_schedule_pc2.sv | 15 +
 rtl/des_key_schedule.sv | 91 +++++++++
 tb/tb_des_key_schedule.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/des_key_schedule_pkg.sv
// Shared tables, FSM encoding and permutation helpers for the DES key schedule.
package des_key_schedule_pkg;

    localparam int unsigned NUM_ROUNDS = 16;

    typedef enum logic [1:0] {StIdle, StLoad, StGen, StDone} state_e;

    // DES bit numbers (1 = MSB) selected by PC-1; parity bits 8,16,..,64 never appear.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // DES bit numbers of the 56-bit C||D pair selected by PC-2.
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount applied before each round key; sums to 28.
    localparam logic [1:0] SHIFT [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Handshake and storage-write bundle between the key schedule and its neighbours.
interface des_key_schedule_if #(
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic [63:0]           key_in;
    logic                  start;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [47:0]           wr_data;
    logic                  done;

    modport master (
        output key_in, start,
        input  busy, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  key_in, start,
        output busy, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// Combinational PC-2: compresses the rotated 56-bit C||D pair into a 48-bit round key.
module des_key_schedule_pc2
    import des_key_schedule_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] kn
);
    // Pure bit selection, DES bit 1 sits at the MSB of both vectors.
    always_comb begin
        kn = '0;
        for (int i = 0; i < 48; i++) begin
            kn[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
    end
endmodule

// File: rtl/des_key_schedule.sv
// Expands a 64-bit DES key into 16 round keys, written to round-key storage in encrypt order.
module des_key_schedule
    import des_key_schedule_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    des_key_schedule_if.slave bus
);
    state_e                state_q, state_d;
    logic [55:0]           cd_q, cd_rot;
    logic [ADDR_WIDTH-1:0] round_q, wr_addr_q;
    logic [47:0]           wr_data_q, key_rnd;
    logic                  wr_en_q, done_q;
    logic                  busy, gen_write, last_round;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: GEN is left once the DEPTH-1 write is on the bus.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StLoad;
            StLoad:  state_d = StGen;
            StGen:   if (wr_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-derived controls; write outputs are registered one cycle ahead of the GEN cycle.
    always_comb begin
        busy       = (state_q != StIdle);
        gen_write  = (state_d == StGen);
        last_round = (round_q == ADDR_WIDTH'(DEPTH - 1));
        cd_rot     = {rol28(cd_q[55:28], SHIFT[round_q]), rol28(cd_q[27:0], SHIFT[round_q])};
    end

    des_key_schedule_pc2 u_pc2 (
        .cd (cd_rot),
        .kn (key_rnd)
    );

    // Datapath: C/D pair, round counter and the registered storage-write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_q      <= '0;
            round_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            if (state_q == StIdle && bus.start) begin
                cd_q <= pc1(bus.key_in);
            end else if (gen_write) begin
                cd_q <= cd_rot;
            end

            if (gen_write) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= round_q;
                wr_data_q <= key_rnd;
                round_q   <= last_round ? '0 : round_q + ADDR_WIDTH'(1);
            end else begin
                // Idle write port holds zeros so storage sees a harmless read.
                wr_en_q   <= 1'b0;
                wr_addr_q <= '0;
                wr_data_q <= '0;
                round_q   <= '0;
            end

            done_q <= (state_d == StDone);
        end
    end

    assign bus.busy    = busy;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised self-checking bench for des_key_schedule against a software DES key-schedule model.
`timescale 1ns/1ps
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    des_key_schedule_if #(.ADDR_WIDTH(4)) bus ();

    des_key_schedule #(
        .DEPTH      (16),
        .ADDR_WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Round key n straight from the DES definition: PC-1, total rotation so far, PC-2.
    function automatic logic [47:0] model_key(input logic [63:0] key, input int n);
        logic [63:0] cd, c, d, k;
        int s;
        cd = 64'd0;
        for (int i = 0; i < 56; i++) cd = (cd << 1) | ((key >> (64 - PC1_T[i])) & 64'd1);
        c = cd >> 28;
        d = cd & 64'hFFFFFFF;
        s = 0;
        for (int j = 0; j <= n; j++) s += SHIFTS[j];
        c = ((c << s) | (c >> (28 - s))) & 64'hFFFFFFF;
        d = ((d << s) | (d >> (28 - s))) & 64'hFFFFFFF;
        cd = (c << 28) | d;
        k = 64'd0;
        for (int i = 0; i < 48; i++) k = (k << 1) | ((cd >> (56 - PC2_T[i])) & 64'd1);
        return k[47:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model timeline: cycle of the accepted start, and the keys that schedule must emit.
    int          cyc = 0;
    int          t_acc = 0;
    bit          active = 0;
    logic [47:0] exp_keys [16];
    logic [47:0] cap [16];
    int          wen_cnt = 0;
    logic        s_start, s_rst;
    logic [63:0] s_key;
    int          rel;
    logic [54:0] exp_v, act_v;

    // Per-cycle compare: inputs sampled at the edge, outputs checked 1 ns later.
    always @(posedge clk) begin
        s_start = bus.start;
        s_key   = bus.key_in;
        s_rst   = rst_n;
        cyc++;
        #1;
        if (!s_rst) begin
            active = 0;
        end else if (s_start && (!active || (cyc - t_acc) >= 19)) begin
            active = 1;
            t_acc  = cyc;
            for (int n = 0; n < 16; n++) exp_keys[n] = model_key(s_key, n);
        end
        rel   = active ? (cyc - t_acc) : 1000;
        exp_v = '0;
        if (rel <= 17) exp_v[54] = 1'b1;
        if (rel >= 1 && rel <= 16) begin
            exp_v[53]    = 1'b1;
            exp_v[52:49] = 4'(rel - 1);
            exp_v[48:1]  = exp_keys[rel - 1];
        end
        if (rel == 17) exp_v[0] = 1'b1;
        act_v = {bus.busy, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done};
        check("cycle busy/wr_en/wr_addr/wr_data/done", 64'(act_v), 64'(exp_v));
        if (bus.wr_en === 1'b1) begin
            cap[bus.wr_addr] = bus.wr_data;
            wen_cnt++;
        end
    end

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL wait_done: done not seen, required within %0d cycles", max_cycles);
        end
    endtask

    task automatic pulse_start(input logic [63:0] key);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = {$urandom, $urandom};
    endtask

    initial begin
        logic [63:0] k;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.key_in = '0;
        for (int i = 0; i < 16; i++) cap[i] = '0;

        // Pin the model to the textbook vector.
        check("model K1", 64'(model_key(VEC_KEY, 0)), 64'h1B02EFFC7072);
        check("model K2", 64'(model_key(VEC_KEY, 1)), 64'h79AED9DBC9E5);
        check("model K16", 64'(model_key(VEC_KEY, 15)), 64'hCB3D8B0E17F5);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known vector, with a second start at T+5 that must be ignored.
        wen_cnt = 0;
        pulse_start(VEC_KEY);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = 64'h0F1571C947D9E859;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40);
        repeat (2) @(negedge clk);
        check("vector addr0", 64'(cap[0]), 64'h1B02EFFC7072);
        check("vector addr1", 64'(cap[1]), 64'h79AED9DBC9E5);
        check("vector addr15", 64'(cap[15]), 64'hCB3D8B0E17F5);
        check("vector wr_en cycles", 64'(wen_cnt), 64'd16);

        // Reset mid-run clears outputs at once; then a zero key rewrites all 16 slots.
        pulse_start({$urandom, $urandom});
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              64'({bus.busy, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(64'd0);
        wait_done(40);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) check("zero-key slot", 64'(cap[i]), 64'd0);

        // Start held high: schedules run back to back, key sampled only on acceptance.
        @(negedge clk);
        bus.start = 1'b1;
        fork
            begin
                repeat (3) wait_done(40);
            end
            begin
                repeat (70) begin
                    bus.key_in = {$urandom, $urandom};
                    @(negedge clk);
                end
            end
        join_any
        disable fork;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // 100 random keys, each read back from the storage image.
        for (int t = 0; t < 100; t++) begin
            k = {$urandom, $urandom};
            pulse_start(k);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 14)) @(negedge clk);
                pulse_start({$urandom, $urandom});
            end
            wait_done(40);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            for (int i = 0; i < 16; i++) check("random readback", 64'(cap[i]), 64'(model_key(k, i)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule
